playfield_engine: RTL and testbench
===================================

# playfield_engine

Parametrised successor to the fixed 10×12 Tetris game-array controller. Owns the settled-block playfield, runs the game state machine (idle, spawn, play, clear, lost), stamps locked pieces, and clears any number of full rows per lock. Also keeps score and a total-lines counter. Sits between the piece mover, which supplies coordinates and flags, and the VGA/display logic, which reads the flattened field.

## Interface
Parameters:
- COLS, default 10, playfield width in cells.
- ROWS, default 12, playfield height in cells.
- CW, default 4, coordinate width; must satisfy 2^CW ≥ max(COLS, ROWS).
- SCORE_W, default 16, width of the score and lines counters.
- POINTS, default 10, base points per cleared line.

Ports (clock and reset first):
- Clk, in, 1: sole clock, rising edge.
- Reset_n, in, 1: asynchronous, active-low reset.
- Start, in, 1: begin a game; sampled in IDLE only.
- Ack, in, 1: acknowledge game over; sampled in LOST only.
- bottom_flag, in, 1: piece has landed; sampled in PLAY only.
- top_flag, in, 1: spawn collision, meaning game over; sampled in PLAY only.
- px, in, 4*CW: column of cells 0..3, cell k in bits [k*CW +: CW].
- py, in, 4*CW: row of cells 0..3, same packing.
- state, out, 5: one-hot {LOST, CLEAR, PLAY, SPAWN, IDLE}.
- gen_flag, out, 1: high when state is SPAWN.
- started, out, 1: high when state is not IDLE.
- field, out, ROWS*COLS: bit r*COLS+c is cell (row r, column c); row 0 is the top row and row ROWS-1 is the bottom row.
- score, out, SCORE_W: accumulated points.
- lines, out, SCORE_W: total lines cleared this game.
- clear_busy, out, 1: high when state is CLEAR.

## Operation
Reset values:
- state = IDLE.
- field, score and lines = 0.

State machine:
- IDLE: field is held at 0. On Start, score and lines are set to 0 and the next state is SPAWN.
- SPAWN: lasts exactly 1 cycle, then PLAY. This cycle is the new-piece request.
- PLAY: top_flag has priority; it moves to LOST with no stamp. Otherwise bottom_flag sets the four cells (py[k], px[k]) in field, clears the per-lock line count n, and moves to CLEAR. With neither flag set, the state holds.
- CLEAR, each cycle:
  - Find the lowest (highest-index) full row f.
  - If f exists: rows 1..f each take the row above them, row 0 becomes 0, and n increments.
  - If no row is full: score += award(n), lines += n, next state SPAWN.
- LOST: field and score are frozen. On Ack, next state is IDLE.

Stamp rules:
- Any cell with px ≥ COLS or py ≥ ROWS is ignored; it causes no write and no wrap.
- Duplicate coordinates are harmless.

Arithmetic:
- score and lines saturate at 2^SCORE_W−1 and never wrap.
- award(0) = 0.
- award(n) without the macro = n*POINTS.

Simultaneous events:
- top_flag together with bottom_flag goes to LOST.
- Start outside IDLE and Ack outside LOST are ignored.

Reset mid-operation: Reset_n low at any point, including mid-CLEAR, immediately forces the reset values. There is no partial shift and no score update.

## Timing
- Start high at edge t, sampled in IDLE → state = SPAWN after t; PLAY after t+1.
- bottom_flag sampled at edge t → stamped cells visible on field and state = CLEAR after t.
- A lock that completes k full rows spends k+1 cycles in CLEAR, so CLEAR is at most 5 cycles. score and lines update on the edge that leaves CLEAR, so they are valid when state = SPAWN.
- Outputs are registered, or decoded from state only; there are no combinational paths from inputs to outputs.

## Configuration
- PF_COMBO_SCORE_EN defined: award(n) = POINTS × {1, 3, 5, 8} for n = 1..4. For n > 4 (possible only when ROWS/COLS allow), award(n) = 8*POINTS + (n−4)*POINTS.
- PF_COMBO_SCORE_EN undefined: award(n) = n*POINTS.
- lines behaves the same in both builds.

## Test plan
- Reset, then Start pulse → state sequence IDLE, SPAWN, PLAY; field = 0; score = 0; gen_flag high for exactly 1 cycle.
- Bottom row 11 pre-filled in columns 0–5; lock a piece with cells (11,6), (11,7), (11,8), (11,9) → CLEAR lasts 2 cycles, row 11 = 0, lines = 1, score = 10.
- Rows 8–11 full except column 9; lock a vertical I-piece at column 9, rows 8–11 → 5 CLEAR cycles, field = 0, lines = 4, score = 40 without the macro and 80 with it.
- Non-contiguous full rows 9 and 11, with row 10 containing pattern P → after CLEAR, row 11 = P, rows 0–10 = 0, and score increases by 20 (30 with the macro).
- top_flag and bottom_flag high together in PLAY → LOST, field unchanged; Start ignored; Ack → IDLE, score retained until the next Start.
- Preload score = 65530 and lock one line, plus a separate case with px = 12 out of range → score saturates at 65535, and the out-of-range cell leaves field unwritten; Reset_n asserted mid-CLEAR → all outputs return to their reset values.

Source files
------------

// File: rtl/playfield_engine.sv
// Settled-block playfield and game FSM: stamps locked pieces, clears full rows one per cycle, keeps score/lines.
// Optional macro PF_COMBO_SCORE_EN selects combo scoring {1,3,5,8}xPOINTS; all outputs are registered or state-decoded.
module playfield_engine #(
    parameter int COLS    = 10,
    parameter int ROWS    = 12,
    parameter int CW      = 4,
    parameter int SCORE_W = 16,
    parameter int POINTS  = 10
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    input  logic                    Ack,
    input  logic                    bottom_flag,
    input  logic                    top_flag,
    input  logic [4*CW-1:0]         px,
    input  logic [4*CW-1:0]         py,
    output logic [4:0]              state,
    output logic                    gen_flag,
    output logic                    started,
    output logic [ROWS*COLS-1:0]    field,
    output logic [SCORE_W-1:0]      score,
    output logic [SCORE_W-1:0]      lines,
    output logic                    clear_busy
);

    localparam int NW = CW + 1;
    localparam logic [SCORE_W-1:0] SAT = {SCORE_W{1'b1}};

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_SPAWN = 5'b00010,
        S_PLAY  = 5'b00100,
        S_CLEAR = 5'b01000,
        S_LOST  = 5'b10000
    } state_t;

    state_t                 state_q, state_d;
    logic [ROWS*COLS-1:0]   field_q, field_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [SCORE_W-1:0]     lines_q, lines_d;
    logic [NW-1:0]          n_q, n_d;

    logic [ROWS*COLS-1:0]   stamp;
    logic [ROWS*COLS-1:0]   shifted;
    logic                   found;
    logic [CW-1:0]          f_row;
    logic [63:0]            score_sum;
    logic [63:0]            lines_sum;

    function automatic logic [63:0] award(input logic [NW-1:0] n);
        logic [63:0] mult;
`ifdef PF_COMBO_SCORE_EN
        case (n)
            NW'(0):  mult = 64'd0;
            NW'(1):  mult = 64'd1;
            NW'(2):  mult = 64'd3;
            NW'(3):  mult = 64'd5;
            NW'(4):  mult = 64'd8;
            default: mult = 64'(n) + 64'd4;
        endcase
`else
        mult = 64'(n);
`endif
        return mult * 64'(POINTS);
    endfunction

    // Out-of-range coordinates simply never match a cell, so they cannot wrap.
    always_comb begin
        stamp = '0;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (py[k*CW +: CW] == CW'(r) && px[k*CW +: CW] == CW'(c)) begin
                        stamp[r*COLS + c] = 1'b1;
                    end
                end
            end
        end
    end

    // Lowest full row wins; rows at or above it drop by one.
    always_comb begin
        found = 1'b0;
        f_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (&field_q[r*COLS +: COLS]) begin
                found = 1'b1;
                f_row = CW'(r);
            end
        end
        shifted = field_q;
        if (found) begin
            shifted[0 +: COLS] = '0;
            for (int r = 1; r < ROWS; r++) begin
                if (CW'(r) <= f_row) begin
                    shifted[r*COLS +: COLS] = field_q[(r-1)*COLS +: COLS];
                end
            end
        end
    end

    assign score_sum = 64'(score_q) + award(n_q);
    assign lines_sum = 64'(lines_q) + 64'(n_q);

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        score_d = score_q;
        lines_d = lines_q;
        n_d     = n_q;
        case (state_q)
            S_IDLE: begin
                field_d = '0;
                if (Start) begin
                    score_d = '0;
                    lines_d = '0;
                    state_d = S_SPAWN;
                end
            end
            S_SPAWN: state_d = S_PLAY;
            S_PLAY: begin
                if (top_flag) begin
                    state_d = S_LOST;
                end else if (bottom_flag) begin
                    field_d = field_q | stamp;
                    n_d     = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (found) begin
                    field_d = shifted;
                    n_d     = n_q + NW'(1);
                end else begin
                    score_d = (score_sum > 64'(SAT)) ? SAT : score_sum[SCORE_W-1:0];
                    lines_d = (lines_sum > 64'(SAT)) ? SAT : lines_sum[SCORE_W-1:0];
                    state_d = S_SPAWN;
                end
            end
            S_LOST: begin
                if (Ack) begin
                    field_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            field_q <= '0;
            score_q <= '0;
            lines_q <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            score_q <= score_d;
            lines_q <= lines_d;
            n_q     <= n_d;
        end
    end

    assign state      = state_q;
    assign gen_flag   = (state_q == S_SPAWN);
    assign started    = (state_q != S_IDLE);
    assign clear_busy = (state_q == S_CLEAR);
    assign field      = field_q;
    assign score      = score_q;
    assign lines      = lines_q;

endmodule

// File: tb/tb_playfield_engine.sv
// Directed bench for playfield_engine; a second instance with a 5-bit score exercises saturation.
module tb_playfield_engine;
    localparam logic [4:0] IDLE = 5'd1, SPAWN = 5'd2, PLAY = 5'd4, CLEAR = 5'd8, LOST = 5'd16;
`ifdef PF_COMBO_SCORE_EN
    localparam bit COMBO = 1'b1;
`else
    localparam bit COMBO = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset_n, Start, Ack, bottom_flag, top_flag;
    logic [15:0]  px, py;
    logic [4:0]   state, state2;
    logic         gen_flag, started, clear_busy, gen_flag2, started2, clear_busy2;
    logic [119:0] field, field2;
    logic [15:0]  score, lines;
    logic [4:0]   score2, lines2;

    int errors = 0;
    int checks = 0;
    int cyc;

    playfield_engine dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack),
        .bottom_flag(bottom_flag), .top_flag(top_flag), .px(px), .py(py),
        .state(state), .gen_flag(gen_flag), .started(started), .field(field),
        .score(score), .lines(lines), .clear_busy(clear_busy)
    );

    playfield_engine #(.SCORE_W(5)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack),
        .bottom_flag(bottom_flag), .top_flag(top_flag), .px(px), .py(py),
        .state(state2), .gen_flag(gen_flag2), .started(started2), .field(field2),
        .score(score2), .lines(lines2), .clear_busy(clear_busy2)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] p4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [119:0] rowv(input int r, input logic [9:0] p);
        logic [119:0] v;
        v = 120'(p);
        return v << (r * 10);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic lock(input logic [15:0] x, input logic [15:0] y);
        px = x;
        py = y;
        bottom_flag = 1'b1;
        tick();
        bottom_flag = 1'b0;
    endtask

    task automatic settle(output int n);
        n = 0;
        while (state == CLEAR && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic lock_settle(input logic [15:0] x, input logic [15:0] y);
        int n;
        lock(x, y);
        settle(n);
        tick();
        check("fill_play", 128'(state), 128'(PLAY));
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Ack = 1'b0;
        bottom_flag = 1'b0; top_flag = 1'b0; px = '0; py = '0;
        tick();
        check("rst_state", 128'(state), 128'(IDLE));
        check("rst_field", 128'(field), 128'(0));
        check("rst_score", 128'(score), 128'(0));
        check("rst_lines", 128'(lines), 128'(0));
        check("rst_gen", 128'(gen_flag), 128'(0));
        check("rst_started", 128'(started), 128'(0));
        Reset_n = 1'b1;
        tick();

        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("start_spawn", 128'(state), 128'(SPAWN));
        check("start_gen", 128'(gen_flag), 128'(1));
        check("start_started", 128'(started), 128'(1));
        tick();
        check("start_play", 128'(state), 128'(PLAY));
        check("start_gen_off", 128'(gen_flag), 128'(0));
        check("start_field", 128'(field), 128'(0));

        // single line on the bottom row
        lock_settle(p4(0, 1, 2, 3), p4(11, 11, 11, 11));
        check("a_pref1", 128'(field), 128'(rowv(11, 10'h00F)));
        lock_settle(p4(4, 5, 0, 0), p4(11, 11, 15, 15));
        check("a_pref2", 128'(field), 128'(rowv(11, 10'h03F)));
        lock(p4(6, 7, 8, 9), p4(11, 11, 11, 11));
        check("a_stamp_state", 128'(state), 128'(CLEAR));
        check("a_stamp_field", 128'(field), 128'(rowv(11, 10'h3FF)));
        check("a_busy", 128'(clear_busy), 128'(1));
        settle(cyc);
        check("a_clear_cycles", 128'(cyc), 128'(2));
        check("a_spawn", 128'(state), 128'(SPAWN));
        check("a_field", 128'(field), 128'(0));
        check("a_lines", 128'(lines), 128'(1));
        check("a_score", 128'(score), 128'(10));
        check("a_score2", 128'(score2), 128'(10));
        tick();

        // four lines with a vertical I in column 9
        for (int c = 0; c < 9; c++) lock_settle(p4(c, c, c, c), p4(8, 9, 10, 11));
        check("b_pref", 128'(field),
              128'(rowv(8, 10'h1FF) | rowv(9, 10'h1FF) | rowv(10, 10'h1FF) | rowv(11, 10'h1FF)));
        lock(p4(9, 9, 9, 9), p4(8, 9, 10, 11));
        check("b_stamp_field", 128'(field),
              128'(rowv(8, 10'h3FF) | rowv(9, 10'h3FF) | rowv(10, 10'h3FF) | rowv(11, 10'h3FF)));
        settle(cyc);
        check("b_clear_cycles", 128'(cyc), 128'(5));
        check("b_field", 128'(field), 128'(0));
        check("b_lines", 128'(lines), 128'(5));
        check("b_score", 128'(score), 128'(COMBO ? 90 : 50));
        check("b_score2_sat", 128'(score2), 128'(31));
        check("b_lines2", 128'(lines2), 128'(5));
        tick();

        // rows 9 and 11 full, row 10 keeps a pattern
        lock_settle(p4(0, 1, 2, 3), p4(9, 9, 9, 9));
        lock_settle(p4(4, 5, 6, 7), p4(9, 9, 9, 9));
        lock_settle(p4(0, 1, 2, 3), p4(11, 11, 11, 11));
        lock_settle(p4(4, 5, 6, 7), p4(11, 11, 11, 11));
        lock_settle(p4(0, 2, 4, 4), p4(10, 10, 10, 10));
        check("c_pref", 128'(field),
              128'(rowv(9, 10'h0FF) | rowv(10, 10'h015) | rowv(11, 10'h0FF)));
        lock(p4(8, 9, 8, 9), p4(9, 9, 11, 11));
        settle(cyc);
        check("c_clear_cycles", 128'(cyc), 128'(3));
        check("c_field", 128'(field), 128'(rowv(11, 10'h015)));
        check("c_lines", 128'(lines), 128'(7));
        check("c_score", 128'(score), 128'(COMBO ? 120 : 70));
        check("c_score2", 128'(score2), 128'(31));
        tick();

        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check("ack_in_play", 128'(state), 128'(PLAY));

        // out-of-range cells must neither write nor wrap
        lock(p4(12, 3, 12, 15), p4(0, 12, 5, 13));
        check("oor_state", 128'(state), 128'(CLEAR));
        check("oor_field", 128'(field), 128'(rowv(11, 10'h015)));
        settle(cyc);
        check("oor_cycles", 128'(cyc), 128'(1));
        check("oor_score", 128'(score), 128'(COMBO ? 120 : 70));
        tick();

        top_flag = 1'b1; bottom_flag = 1'b1;
        px = p4(0, 1, 2, 3); py = p4(0, 0, 0, 0);
        tick();
        top_flag = 1'b0; bottom_flag = 1'b0;
        check("lost_state", 128'(state), 128'(LOST));
        check("lost_field", 128'(field), 128'(rowv(11, 10'h015)));
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("lost_start_ign", 128'(state), 128'(LOST));
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check("ack_idle", 128'(state), 128'(IDLE));
        check("ack_field", 128'(field), 128'(0));
        check("ack_score_kept", 128'(score), 128'(COMBO ? 120 : 70));
        check("ack_lines_kept", 128'(lines), 128'(7));
        check("ack_started", 128'(started), 128'(0));
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("new_spawn", 128'(state), 128'(SPAWN));
        check("new_score", 128'(score), 128'(0));
        check("new_lines", 128'(lines), 128'(0));
        check("new_score2", 128'(score2), 128'(0));
        tick();

        lock_settle(p4(0, 1, 2, 3), p4(11, 11, 11, 11));
        lock_settle(p4(4, 5, 6, 7), p4(11, 11, 11, 11));
        lock(p4(8, 9, 0, 1), p4(11, 11, 10, 10));
        settle(cyc);
        check("d_field", 128'(field), 128'(rowv(11, 10'h003)));
        check("d_score", 128'(score), 128'(10));
        tick();
        lock_settle(p4(2, 3, 4, 5), p4(11, 11, 11, 11));
        lock(p4(6, 7, 8, 9), p4(11, 11, 11, 11));
        tick();
        check("d_mid_clear", 128'(clear_busy), 128'(1));
        #1 Reset_n = 1'b0;
        #1;
        check("mrst_state", 128'(state), 128'(IDLE));
        check("mrst_field", 128'(field), 128'(0));
        check("mrst_score", 128'(score), 128'(0));
        check("mrst_lines", 128'(lines), 128'(0));
        check("mrst_busy", 128'(clear_busy), 128'(0));
        check("mrst_gen", 128'(gen_flag), 128'(0));
        check("mrst_started", 128'(started), 128'(0));
        tick();
        Reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
